sysbus_arbiter: RTL and testbench

SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

---
 rtl/sysbus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// ============================================================================
// Module   : sysbus_arbiter
// Brief    : Two-requester (icache/dcache) system bus arbiter with turnaround
//            cycle; optional tenure limit enabled by SYSBUS_ARB_TENURE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      icache_bus_assert,
    input  logic                      icache_bus_reqcyc,
    input  logic                      icache_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] icache_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  icache_bus_reqtag,
    output logic                      icache_has_bus,
    output logic                      icache_bus_reqack,
    output logic                      icache_bus_respcyc,

    input  logic                      dcache_bus_assert,
    input  logic                      dcache_bus_reqcyc,
    input  logic                      dcache_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] dcache_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dcache_bus_reqtag,
    output logic                      dcache_has_bus,
    output logic                      dcache_bus_reqack,
    output logic                      dcache_bus_respcyc,

    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OWN_I      = 2'd1,
        OWN_D      = 2'd2,
        TURNAROUND = 2'd3
    } state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } owner_t;

    state_t r_state;
    state_t w_next_state;
    owner_t r_last_owner;
    owner_t w_next_last_owner;
    logic   r_icache_has_bus;
    logic   r_dcache_has_bus;
    logic   w_expire_i;
    logic   w_expire_d;

`ifdef SYSBUS_ARB_TENURE_EN
    logic [7:0] r_tenure;

    // Ownership is only ever entered from IDLE, so clearing there is the entry clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tenure <= 8'd0;
        end else if (r_state == IDLE) begin
            r_tenure <= 8'd0;
        end else if ((r_state == OWN_I || r_state == OWN_D) && r_tenure != 8'hFF) begin
            r_tenure <= r_tenure + 8'd1;
        end
    end

    // Counter reads 254 in the 255th owned cycle and would reach 255 on the exit edge.
    assign w_expire_i = (r_tenure == 8'd254) && dcache_bus_assert && !bus_respcyc;
    assign w_expire_d = (r_tenure == 8'd254) && icache_bus_assert && !bus_respcyc;
`else
    assign w_expire_i = 1'b0;
    assign w_expire_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_last_owner     <= LAST_D;
            r_icache_has_bus <= 1'b0;
            r_dcache_has_bus <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_last_owner     <= w_next_last_owner;
            r_icache_has_bus <= (w_next_state == OWN_I);
            r_dcache_has_bus <= (w_next_state == OWN_D);
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_owner = r_last_owner;
        case (r_state)
            IDLE: begin
                if (icache_bus_assert && dcache_bus_assert) begin
                    w_next_state = (r_last_owner == LAST_D) ? OWN_I : OWN_D;
                end else if (icache_bus_assert) begin
                    w_next_state = OWN_I;
                end else if (dcache_bus_assert) begin
                    w_next_state = OWN_D;
                end
            end
            OWN_I: begin
                if (!icache_bus_assert || w_expire_i) begin
                    w_next_state      = TURNAROUND;
                    w_next_last_owner = LAST_I;
                end
            end
            OWN_D: begin
                if (!dcache_bus_assert || w_expire_d) begin
                    w_next_state      = TURNAROUND;
                    w_next_last_owner = LAST_D;
                end
            end
            TURNAROUND: w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Only the current owner reaches the system bus; everything else sees zeros.
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        case (r_state)
            OWN_I: begin
                bus_reqcyc  = icache_bus_reqcyc;
                bus_respack = icache_bus_respack;
                bus_req     = icache_bus_req;
                bus_reqtag  = icache_bus_reqtag;
            end
            OWN_D: begin
                bus_reqcyc  = dcache_bus_reqcyc;
                bus_respack = dcache_bus_respack;
                bus_req     = dcache_bus_req;
                bus_reqtag  = dcache_bus_reqtag;
            end
            default: ;
        endcase
    end

    assign icache_has_bus     = r_icache_has_bus;
    assign dcache_has_bus     = r_dcache_has_bus;
    assign icache_bus_reqack  = bus_reqack  && (r_state == OWN_I);
    assign dcache_bus_reqack  = bus_reqack  && (r_state == OWN_D);
    assign icache_bus_respcyc = bus_respcyc && (r_state == OWN_I);
    assign dcache_bus_respcyc = bus_respcyc && (r_state == OWN_D);

endmodule

`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
// ============================================================================
// Module   : tb_sysbus_arbiter
// Brief    : Directed self-checking bench for sysbus_arbiter (scoreboard queue).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sysbus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int VW = 2 + 4 + 2 + DW + TW;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_bus_assert, icache_bus_reqcyc, icache_bus_respack;
    logic [DW-1:0] icache_bus_req;
    logic [TW-1:0] icache_bus_reqtag;
    logic          icache_has_bus, icache_bus_reqack, icache_bus_respcyc;
    logic          dcache_bus_assert, dcache_bus_reqcyc, dcache_bus_respack;
    logic [DW-1:0] dcache_bus_req;
    logic [TW-1:0] dcache_bus_reqtag;
    logic          dcache_has_bus, dcache_bus_reqack, dcache_bus_respcyc;
    logic          bus_reqack, bus_respcyc, bus_reqcyc, bus_respack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;

    int n_checks = 0;
    int n_pass   = 0;

    logic [VW-1:0] exp_q[$];
    string         tag_q[$];

    sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
        .clk                (clk),
        .reset              (reset),
        .icache_bus_assert  (icache_bus_assert),
        .icache_bus_reqcyc  (icache_bus_reqcyc),
        .icache_bus_respack (icache_bus_respack),
        .icache_bus_req     (icache_bus_req),
        .icache_bus_reqtag  (icache_bus_reqtag),
        .icache_has_bus     (icache_has_bus),
        .icache_bus_reqack  (icache_bus_reqack),
        .icache_bus_respcyc (icache_bus_respcyc),
        .dcache_bus_assert  (dcache_bus_assert),
        .dcache_bus_reqcyc  (dcache_bus_reqcyc),
        .dcache_bus_respack (dcache_bus_respack),
        .dcache_bus_req     (dcache_bus_req),
        .dcache_bus_reqtag  (dcache_bus_reqtag),
        .dcache_has_bus     (dcache_has_bus),
        .dcache_bus_reqack  (dcache_bus_reqack),
        .dcache_bus_respcyc (dcache_bus_respcyc),
        .bus_reqack         (bus_reqack),
        .bus_respcyc        (bus_respcyc),
        .bus_reqcyc         (bus_reqcyc),
        .bus_respack        (bus_respack),
        .bus_req            (bus_req),
        .bus_reqtag         (bus_reqtag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected output vector for a given owner (0 none, 1 icache, 2 dcache).
    function automatic logic [VW-1:0] model(input int own);
        logic oi, od;
        logic rc, ra;
        logic [DW-1:0] rq;
        logic [TW-1:0] rt;
        oi = (own == 1);
        od = (own == 2);
        rc = oi ? icache_bus_reqcyc  : od ? dcache_bus_reqcyc  : 1'b0;
        ra = oi ? icache_bus_respack : od ? dcache_bus_respack : 1'b0;
        rq = oi ? icache_bus_req     : od ? dcache_bus_req     : '0;
        rt = oi ? icache_bus_reqtag  : od ? dcache_bus_reqtag  : '0;
        return {oi, od, bus_reqack & oi, bus_reqack & od,
                bus_respcyc & oi, bus_respcyc & od, rc, ra, rq, rt};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {icache_has_bus, dcache_has_bus, icache_bus_reqack, dcache_bus_reqack,
                icache_bus_respcyc, dcache_bus_respcyc, bus_reqcyc, bus_respack,
                bus_req, bus_reqtag};
    endfunction

    // Push expectation for the current cycle, compare at negedge, advance to next cycle.
    task automatic chk(input string name, input int own);
        logic [VW-1:0] e, o;
        string t;
        exp_q.push_back(model(own));
        tag_q.push_back(name);
        @(negedge clk);
        o = observed();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", t, o, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset              = 1'b0;
        icache_bus_assert  = 1'b0;
        icache_bus_reqcyc  = 1'b1;
        icache_bus_respack = 1'b1;
        icache_bus_req     = 64'h1111_2222_3333_4444;
        icache_bus_reqtag  = 13'h0A5;
        dcache_bus_assert  = 1'b0;
        dcache_bus_reqcyc  = 1'b1;
        dcache_bus_respack = 1'b1;
        dcache_bus_req     = 64'hDEAD;
        dcache_bus_reqtag  = 13'h15A;
        bus_reqack         = 1'b1;
        bus_respcyc        = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 0);

        reset = 1'b1;
        chk("idle_after_release", 0);

        icache_bus_assert = 1'b1;
        dcache_bus_assert = 1'b1;
        chk("tie_pending", 0);
        chk("tie_icache_first", 1);

        // dcache strobes without grant must never reach the bus
        for (int i = 0; i < 3; i++) begin
            icache_bus_req    = 64'hCAFE_0000 + 64'(i);
            icache_bus_reqtag = 13'(i + 7);
            chk("nonowner_blocked", 1);
        end

        icache_bus_reqcyc = 1'b0;
        bus_reqack        = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus_respcyc    = 1'b1;
            icache_bus_req = 64'(i);
            chk("resp_burst_icache", 1);
        end

        icache_bus_assert = 1'b0;
        chk("drop_still_own_i", 1);
        chk("turnaround_i", 0);
        chk("late_resp_idle", 0);
        bus_respcyc       = 1'b0;
        dcache_bus_reqcyc = 1'b1;
        dcache_bus_req    = 64'h0BAD_F00D;
        chk("grant_dcache", 2);
        bus_reqack = 1'b1;
        chk("dcache_reqack", 2);

        // Asynchronous reset in the middle of a dcache tenure
        icache_bus_assert = 1'b1;
        reset = 1'b0;
        chk("reset_mid_own_d", 0);
        reset = 1'b1;
        chk("idle_after_mid_reset", 0);
        chk("post_reset_tie_icache", 1);

        icache_bus_assert = 1'b0;
        dcache_bus_assert = 1'b0;
        chk("own_i_drop_both", 1);
        chk("turnaround_before_seq", 0);

        // dcache asserts at cycle 0 and drops at cycle 10; icache joins at cycle 5
        for (int k = 0; k <= 13; k++) begin
            int own;
            dcache_bus_assert = (k < 10);
            icache_bus_assert = (k >= 5);
            dcache_bus_req    = 64'hD000 + 64'(k);
            icache_bus_req    = 64'hA000 + 64'(k);
            if (k == 0)            own = 0;
            else if (k <= 10)      own = 2;
            else if (k <= 12)      own = 0;
            else                   own = 1;
            chk($sformatf("seq_cycle_%0d", k), own);
        end

        // icache keeps asserting against a waiting dcache with no responses
        dcache_bus_assert = 1'b1;
        bus_respcyc       = 1'b0;
        for (int j = 1; j < 300; j++) begin
            int own;
            icache_bus_req = 64'h5000 + 64'(j);
`ifdef SYSBUS_ARB_TENURE_EN
            if (j < 255)       own = 1;
            else if (j < 257)  own = 0;
            else               own = 2;
`else
            own = 1;
`endif
            chk($sformatf("tenure_%0d", j), own);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
